// File: rtl/ft_pkg.sv
// Shared types and constants for the Goertzel spectrum engine control path.
package ft_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_C_REQ,
        S_C_WR,
        S_READY,
        S_FRAME,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    localparam int ST_COEF_BUSY  = 0;
    localparam int ST_COEF_READY = 1;
    localparam int ST_FRAME_BUSY = 2;
    localparam int ST_FRAME_DONE = 3;
    localparam int ST_ERR        = 4;

    localparam int DEF_NF = 11;
    localparam int DEF_NS = 100000;

    // Non-sticky status flags implied by a state; coefficients stay valid through every frame state.
    function automatic logic [2:0] state_flags(seq_state_t s);
        logic [2:0] f;
        f = '0;
        f[ST_COEF_BUSY]  = (s == S_C_REQ) || (s == S_C_WR);
        f[ST_COEF_READY] = (s == S_READY) || (s == S_FRAME) || (s == S_DRAIN) || (s == S_DONE);
        f[ST_FRAME_BUSY] = (s == S_FRAME) || (s == S_DRAIN);
        return f;
    endfunction

endpackage

// File: rtl/ft_frame_counter.sv
// Frame sample counter with last-sample detect, plus the timeout counter used while draining.
module ft_frame_counter
    import ft_pkg::*;
#(
    parameter int NS  = DEF_NS,
    parameter int TMO = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic drain,
    output logic last,
    output logic timeout
);
    localparam int CNTW = (NS > 1) ? $clog2(NS) : 1;
    localparam int TW   = (TMO > 1) ? $clog2(TMO) : 1;

    logic [CNTW-1:0] cnt;
    logic [TW-1:0]   tmo_cnt;

    // The final sample leaves the frame instead of incrementing, so cnt never wraps.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !last) begin
            cnt <= cnt + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !drain) begin
            tmo_cnt <= '0;
        end else if (!timeout) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign last    = (cnt == CNTW'(NS - 1));
    assign timeout = drain && (tmo_cnt == TW'(TMO - 1));

endmodule

// File: rtl/goertzel_sequencer.sv
// Shares one CORDIC across all bins to load coefficients, then sequences framed streaming into the bins.
module goertzel_sequencer
    import ft_pkg::*;
#(
    parameter int NF  = DEF_NF,
    parameter int NS  = DEF_NS,
    parameter int FW  = 32,
    parameter int CW  = 32,
    parameter int TMO = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [NF*FW-1:0] freq_i,
    output logic             cordic_req,
    output logic [FW-1:0]    cordic_freq,
    input  logic             cordic_ack,
    input  logic [CW-1:0]    cordic_cos,
    input  logic [CW-1:0]    cordic_sin,
    output logic [NF-1:0]    coef_we,
    output logic [CW-1:0]    coef_cos,
    output logic [CW-1:0]    coef_sin,
    input  logic             run,
    input  logic             sample_valid,
    output logic             bin_clr,
    output logic             bin_en,
    output logic             bin_last,
    input  logic [NF-1:0]    bin_valid,
    output logic             frame_done,
    output logic [4:0]       status
);
    localparam int IW = (NF > 1) ? $clog2(NF) : 1;

    seq_state_t    state;
    logic [IW-1:0] idx;
    logic [2:0]    flags;
    logic          sticky_done;
    logic          sticky_err;
    logic          cfg_allowed;
    logic          cnt_last;
    logic          drain_timeout;

    assign cfg_allowed = (state == S_IDLE) || (state == S_READY) || (state == S_DONE);

    // A reload request in READY wins over starting a frame, so no clear is issued then.
    assign bin_clr  = (state == S_READY) && run && !cfg_start;
    assign bin_en   = (state == S_FRAME) && sample_valid && run;
    assign bin_last = bin_en && cnt_last;
    assign status   = {sticky_err, sticky_done, flags};

    ft_frame_counter #(
        .NS  (NS),
        .TMO (TMO)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (bin_clr),
        .inc     (bin_en),
        .drain   (state == S_DRAIN),
        .last    (cnt_last),
        .timeout (drain_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            flags       <= '0;
            sticky_done <= 1'b0;
            sticky_err  <= 1'b0;
            cordic_req  <= 1'b0;
            cordic_freq <= '0;
            coef_we     <= '0;
            coef_cos    <= '0;
            coef_sin    <= '0;
            frame_done  <= 1'b0;
        end else begin
            coef_we    <= '0;
            frame_done <= 1'b0;
            if (cfg_start && !cfg_allowed) begin
                sticky_err <= 1'b1;
            end
            case (state)
                S_IDLE, S_READY, S_DONE: begin
                    if (cfg_start) begin
                        state       <= S_C_REQ;
                        flags       <= state_flags(S_C_REQ);
                        idx         <= '0;
                        cordic_req  <= 1'b1;
                        cordic_freq <= freq_i[FW-1:0];
                        sticky_done <= 1'b0;
                    end else if (state == S_READY && run) begin
                        state       <= S_FRAME;
                        flags       <= state_flags(S_FRAME);
                        sticky_done <= 1'b0;
                    end else if (state == S_DONE) begin
                        state <= S_READY;
                        flags <= state_flags(S_READY);
                    end
                end
                S_C_REQ: begin
                    if (cordic_ack) begin
                        cordic_req <= 1'b0;
                        coef_cos   <= cordic_cos;
                        coef_sin   <= cordic_sin;
                        coef_we    <= NF'(1) << idx;
                        state      <= S_C_WR;
                    end
                end
                S_C_WR: begin
                    if (idx == IW'(NF - 1)) begin
                        state <= S_READY;
                        flags <= state_flags(S_READY);
                    end else begin
                        idx         <= idx + IW'(1);
                        state       <= S_C_REQ;
                        cordic_req  <= 1'b1;
                        cordic_freq <= freq_i[(int'(idx) + 1) * FW +: FW];
                    end
                end
                S_FRAME: begin
                    if (bin_last) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (&bin_valid) begin
                        state       <= S_DONE;
                        flags       <= state_flags(S_DONE);
                        frame_done  <= 1'b1;
                        sticky_done <= 1'b1;
                    end else if (drain_timeout) begin
                        state      <= S_READY;
                        flags      <= state_flags(S_READY);
                        sticky_err <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    flags <= '0;
                end
            endcase
        end
    end

endmodule
